// File: rtl/bdy_op_scheduler_pkg.sv
// Shared types and helpers for the butterfly/PWM body operation scheduler.
package bdy_op_scheduler_pkg;

  // Operation encodings as seen on iCMD_Mode and driven on oFSM_MODE.
  typedef enum logic [2:0] {
    MODE_PWM  = 3'd0,
    MODE_NTT  = 3'd1,
    MODE_INTT = 3'd2
  } mode_e;

  // Scheduler sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Bit positions inside the sticky error vector.
  localparam int ERR_MODE = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_TMO  = 2;

  // Only the three defined operations may start the body.
  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= 3'd2);
  endfunction

  // PWM streams both operands (half-size plus full-size polynomial);
  // the transforms stream one packed polynomial.
  function automatic int in_beats(input logic [2:0] mode, input int coeffs);
    return (mode == MODE_PWM) ? (coeffs / 2 + coeffs) : (coeffs / 2);
  endfunction

  // Every operation returns one packed polynomial.
  function automatic int out_beats(input int coeffs);
    return coeffs / 2;
  endfunction

  // Counter width large enough for the longest input transfer.
  function automatic int cnt_width(input int coeffs);
    return $clog2(coeffs * 3 / 2 + 1);
  endfunction

endpackage

// File: rtl/bdy_op_scheduler_beat_cnt.sv
// Beat counter with a flag marking the final expected beat of a transfer.
module bdy_beat_cnt
  import bdy_op_scheduler_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_target,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Count accepted beats; cleared before each transfer so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_last = (r_count == (i_target - W'(1)));

endmodule

// File: rtl/bdy_op_scheduler.sv
// Command sequencer that configures, starts and streams data through the
// butterfly/PWM body, reporting completion and sticky error flags.
module bdy_op_scheduler
  import bdy_op_scheduler_pkg::*;
#(
  parameter int PRM_DAXI   = 64,
  parameter int PRM_COEFFS = 16,
  parameter int PRM_TMO    = 4096
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iCMD_Valid,
  output logic                oCMD_Ready,
  input  logic [2:0]          iCMD_Mode,
  input  logic [1:0]          iCMD_Q,
  input  logic [4:0]          iCMD_Depth,
  output logic [2:0]          oFSM_MODE,
  output logic [1:0]          oCTL_Q,
  output logic [4:0]          oCTL_NTT_Depth,
  output logic                oFSM_START,
  input  logic                iRs_Tvalid,
  output logic                oRs_Tready,
  input  logic [PRM_DAXI-1:0] iRs_Tdata,
  input  logic                iRs_Tlast,
  output logic                oBs_Tvalid,
  input  logic                iBs_Tready,
  output logic [PRM_DAXI-1:0] oBs_Tdata,
  output logic                oBs_Tlast,
  input  logic                iBm_Tvalid,
  output logic                oBm_Tready,
  input  logic [PRM_DAXI-1:0] iBm_Tdata,
  input  logic                iBm_Tlast,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast,
  output logic                oBUSY,
  output logic                oDONE,
  output logic [2:0]          oERR
);

  localparam int CW = cnt_width(PRM_COEFFS);
  localparam int TW = $clog2(PRM_TMO + 1);

  localparam logic [CW-1:0] IN_PWM   = CW'(in_beats(MODE_PWM, PRM_COEFFS));
  localparam logic [CW-1:0] IN_XFORM = CW'(in_beats(MODE_NTT, PRM_COEFFS));
  localparam logic [CW-1:0] OUT_ALL  = CW'(out_beats(PRM_COEFFS));
  localparam logic [TW-1:0] TMO_LAST = TW'(PRM_TMO - 1);

  state_e      r_state;
  state_e      w_stateNext;
  mode_e       r_mode;
  logic [1:0]  r_q;
  logic [4:0]  r_depth;
  logic [2:0]  r_err;
  logic [2:0]  w_errNext;
  logic        r_illDone;
  logic [TW-1:0] r_tmo;

  logic          w_latch;
  logic          w_illegal;
  logic          w_inEn;
  logic          w_outEn;
  logic          w_inFire;
  logic          w_outFire;
  logic          w_inLast;
  logic          w_outLast;
  logic          w_tmoHit;
  logic [CW-1:0] w_inTarget;

  assign w_inEn     = (r_state == ST_LOAD);
  assign w_outEn    = (r_state == ST_DRAIN);
  assign w_inFire   = w_inEn & iRs_Tvalid & iBs_Tready;
  assign w_outFire  = w_outEn & iBm_Tvalid & iWm_Tready;
  assign w_inTarget = (r_mode == MODE_PWM) ? IN_PWM : IN_XFORM;
  assign w_tmoHit   = (r_tmo == TMO_LAST) & ~w_outFire;

  // Host-to-body stream is a pure combinational gate open only in LOAD.
  assign oBs_Tvalid = w_inEn & iRs_Tvalid;
  assign oRs_Tready = w_inEn & iBs_Tready;
  assign oBs_Tdata  = w_inEn ? iRs_Tdata : '0;
  assign oBs_Tlast  = w_inEn & (iRs_Tlast | w_inLast);

  // Body-to-host stream is a pure combinational gate open only in DRAIN.
  assign oWm_Tvalid = w_outEn & iBm_Tvalid;
  assign oBm_Tready = w_outEn & iWm_Tready;
  assign oWm_Tdata  = w_outEn ? iBm_Tdata : '0;
  assign oWm_Tlast  = w_outEn & w_outLast;

  assign oCMD_Ready     = (r_state == ST_IDLE);
  assign oBUSY          = (r_state != ST_IDLE);
  assign oFSM_START     = (r_state == ST_CFG);
  assign oDONE          = (r_state == ST_DONE) | r_illDone;
  assign oERR           = r_err;
  assign oFSM_MODE      = r_mode;
  assign oCTL_Q         = r_q;
  assign oCTL_NTT_Depth = r_depth;

  bdy_beat_cnt #(.W(CW)) u_inCnt (
    .i_clk    (iSYS_CLK),
    .i_rst    (iSYS_RST),
    .i_clr    (r_state == ST_CFG),
    .i_inc    (w_inFire),
    .i_target (w_inTarget),
    .o_last   (w_inLast)
  );

  bdy_beat_cnt #(.W(CW)) u_outCnt (
    .i_clk    (iSYS_CLK),
    .i_rst    (iSYS_RST),
    .i_clr    (r_state == ST_RUN),
    .i_inc    (w_outFire),
    .i_target (OUT_ALL),
    .o_last   (w_outLast)
  );

  // State register; reset aborts any operation in progress.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and error decisions for the command/stream sequence.
  always_comb begin
    w_stateNext = r_state;
    w_errNext   = r_err;
    w_latch     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iCMD_Valid) begin
          if (!mode_legal(iCMD_Mode)) begin
            w_errNext = 3'b001;
            w_illegal = 1'b1;
          end else begin
            w_errNext   = 3'b000;
            w_latch     = 1'b1;
            w_stateNext = ST_CFG;
          end
        end
      end
      ST_CFG: begin
        w_stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_inFire) begin
          if (w_inLast) begin
            if (!iRs_Tlast) begin
              w_errNext[ERR_LEN] = 1'b1;
            end
            w_stateNext = ST_RUN;
          end else if (iRs_Tlast) begin
            w_errNext[ERR_LEN] = 1'b1;
            w_stateNext = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_tmoHit) begin
          w_errNext[ERR_TMO] = 1'b1;
          w_stateNext = ST_ERR;
        end else if (iBm_Tvalid) begin
          w_stateNext = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_outFire) begin
          if (w_outLast) begin
            if (!iBm_Tlast) begin
              w_errNext[ERR_LEN] = 1'b1;
            end
            w_stateNext = ST_DONE;
          end else if (iBm_Tlast) begin
            w_errNext[ERR_LEN] = 1'b1;
          end
        end else if (w_tmoHit) begin
          w_errNext[ERR_TMO] = 1'b1;
          w_stateNext = ST_ERR;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      ST_ERR: begin
        w_stateNext = ST_ERR;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Body configuration is captured on acceptance and held until the next one.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_mode  <= MODE_PWM;
      r_q     <= '0;
      r_depth <= '0;
    end else if (w_latch) begin
      r_mode  <= mode_e'(iCMD_Mode);
      r_q     <= iCMD_Q;
      r_depth <= iCMD_Depth;
    end
  end

  // Sticky error flags plus the completion pulse for a rejected command.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_err     <= '0;
      r_illDone <= 1'b0;
    end else begin
      r_err     <= w_errNext;
      r_illDone <= w_illegal;
    end
  end

  // Idle-cycle watchdog for the body's response, restarted by every output beat.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_tmo <= '0;
    end else if (((r_state != ST_RUN) && (r_state != ST_DRAIN)) || w_outFire) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_bdy_op_scheduler.sv
// Scoreboard bench for bdy_op_scheduler: drivers push expected beats,
// completions and configs into queues; negedge monitors pop and compare.
module tb_bdy_op_scheduler;

  localparam int DAXI   = 64;
  localparam int COEFFS = 16;
  localparam int TMO    = 4096;

  typedef struct packed {
    logic [DAXI-1:0] data;
    logic            last;
  } beat_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] q;
    logic [4:0] depth;
  } cfg_t;

  logic            clk = 1'b0;
  logic            iSYS_RST;
  logic            iCMD_Valid;
  logic            oCMD_Ready;
  logic [2:0]      iCMD_Mode;
  logic [1:0]      iCMD_Q;
  logic [4:0]      iCMD_Depth;
  logic [2:0]      oFSM_MODE;
  logic [1:0]      oCTL_Q;
  logic [4:0]      oCTL_NTT_Depth;
  logic            oFSM_START;
  logic            iRs_Tvalid;
  logic            oRs_Tready;
  logic [DAXI-1:0] iRs_Tdata;
  logic            iRs_Tlast;
  logic            oBs_Tvalid;
  logic            iBs_Tready;
  logic [DAXI-1:0] oBs_Tdata;
  logic            oBs_Tlast;
  logic            iBm_Tvalid;
  logic            oBm_Tready;
  logic [DAXI-1:0] iBm_Tdata;
  logic            iBm_Tlast;
  logic            oWm_Tvalid;
  logic            iWm_Tready;
  logic [DAXI-1:0] oWm_Tdata;
  logic            oWm_Tlast;
  logic            oBUSY;
  logic            oDONE;
  logic [2:0]      oERR;

  int testCount = 0;
  int errCount  = 0;
  int doneCount = 0;

  beat_t      expBs[$];
  beat_t      expWm[$];
  cfg_t       expCfg[$];
  logic [2:0] expDone[$];

  beat_t      monBs;
  beat_t      monWm;
  cfg_t       monCfg;
  logic [2:0] monErr;

  always #5 clk = ~clk;

  bdy_op_scheduler #(
    .PRM_DAXI   (DAXI),
    .PRM_COEFFS (COEFFS),
    .PRM_TMO    (TMO)
  ) dut (
    .iSYS_CLK       (clk),
    .iSYS_RST       (iSYS_RST),
    .iCMD_Valid     (iCMD_Valid),
    .oCMD_Ready     (oCMD_Ready),
    .iCMD_Mode      (iCMD_Mode),
    .iCMD_Q         (iCMD_Q),
    .iCMD_Depth     (iCMD_Depth),
    .oFSM_MODE      (oFSM_MODE),
    .oCTL_Q         (oCTL_Q),
    .oCTL_NTT_Depth (oCTL_NTT_Depth),
    .oFSM_START     (oFSM_START),
    .iRs_Tvalid     (iRs_Tvalid),
    .oRs_Tready     (oRs_Tready),
    .iRs_Tdata      (iRs_Tdata),
    .iRs_Tlast      (iRs_Tlast),
    .oBs_Tvalid     (oBs_Tvalid),
    .iBs_Tready     (iBs_Tready),
    .oBs_Tdata      (oBs_Tdata),
    .oBs_Tlast      (oBs_Tlast),
    .iBm_Tvalid     (iBm_Tvalid),
    .oBm_Tready     (oBm_Tready),
    .iBm_Tdata      (iBm_Tdata),
    .iBm_Tlast      (iBm_Tlast),
    .oWm_Tvalid     (oWm_Tvalid),
    .iWm_Tready     (iWm_Tready),
    .oWm_Tdata      (oWm_Tdata),
    .oWm_Tlast      (oWm_Tlast),
    .oBUSY          (oBUSY),
    .oDONE          (oDONE),
    .oERR           (oERR)
  );

  task automatic reportFail(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    errCount++;
    $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    if (actual !== expected) begin
      reportFail(name, actual, expected);
    end else begin
      testCount++;
    end
  endtask

  // Host-to-body monitor: every forwarded beat must match the next expected one.
  always @(negedge clk) begin
    if (!iSYS_RST && oBs_Tvalid && iBs_Tready) begin
      if (expBs.size() == 0) begin
        reportFail("bsUnexpectedBeat", oBs_Tdata, 0);
      end else begin
        monBs = expBs.pop_front();
        checkOutput("bsData", oBs_Tdata, monBs.data);
        checkOutput("bsLast", oBs_Tlast, monBs.last);
      end
    end
  end

  // Body-to-host monitor.
  always @(negedge clk) begin
    if (!iSYS_RST && oWm_Tvalid && iWm_Tready) begin
      if (expWm.size() == 0) begin
        reportFail("wmUnexpectedBeat", oWm_Tdata, 0);
      end else begin
        monWm = expWm.pop_front();
        checkOutput("wmData", oWm_Tdata, monWm.data);
        checkOutput("wmLast", oWm_Tlast, monWm.last);
      end
    end
  end

  // Start monitor: each start pulse must carry the configuration of an accepted command.
  always @(negedge clk) begin
    if (!iSYS_RST && oFSM_START) begin
      if (expCfg.size() == 0) begin
        reportFail("startUnexpected", oFSM_MODE, 0);
      end else begin
        monCfg = expCfg.pop_front();
        checkOutput("startMode", oFSM_MODE, monCfg.mode);
        checkOutput("startQ", oCTL_Q, monCfg.q);
        checkOutput("startDepth", oCTL_NTT_Depth, monCfg.depth);
      end
    end
  end

  // Completion monitor: each done pulse must report the expected error vector.
  always @(negedge clk) begin
    if (!iSYS_RST && oDONE) begin
      doneCount++;
      if (expDone.size() == 0) begin
        reportFail("doneUnexpected", oERR, 0);
      end else begin
        monErr = expDone.pop_front();
        checkOutput("doneErr", oERR, monErr);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] mode, input logic [1:0] q, input logic [4:0] depth);
    cfg_t c;
    logic legal;
    legal = (mode <= 3'd2);
    c.mode = mode;
    c.q = q;
    c.depth = depth;
    if (legal) expCfg.push_back(c);
    else expDone.push_back(3'b001);
    iCMD_Valid = 1'b1;
    iCMD_Mode  = mode;
    iCMD_Q     = q;
    iCMD_Depth = depth;
    @(negedge clk);
    checkOutput("cmdReady", oCMD_Ready, 1);
    @(posedge clk);
    #1;
    iCMD_Valid = 1'b0;
    @(negedge clk);
    checkOutput("startAfterAccept", oFSM_START, legal);
    checkOutput("busyAfterAccept", oBUSY, legal);
    checkOutput("rsReadyInCfg", oRs_Tready, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic hostSend(input int n, input int lastAt, input int expLast, input logic [15:0] tag);
    for (int i = 1; i <= n; i++) begin
      beat_t b;
      int    c;
      iRs_Tvalid = 1'b1;
      iRs_Tdata  = (64'(tag) << 32) | 64'(i);
      iRs_Tlast  = (i == lastAt);
      b.data = iRs_Tdata;
      b.last = (i == lastAt) || (i == expLast);
      expBs.push_back(b);
      c = 0;
      @(negedge clk);
      while (!oRs_Tready && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (!oRs_Tready) begin
        reportFail("rsHandshakeTimeout", i, 0);
        iRs_Tvalid = 1'b0;
        iRs_Tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    iRs_Tvalid = 1'b0;
    iRs_Tlast  = 1'b0;
    iRs_Tdata  = '0;
  endtask

  task automatic bodySend(input int n, input int lastAt, input bit toggle, input logic [15:0] tag);
    bit tog = 1'b0;
    for (int i = 1; i <= n; i++) begin
      beat_t b;
      int    c;
      bit    hs;
      iBm_Tvalid = 1'b1;
      iBm_Tdata  = (64'(tag) << 40) | 64'(i * 3);
      iBm_Tlast  = (i == lastAt);
      b.data = iBm_Tdata;
      b.last = (i == n);
      expWm.push_back(b);
      c  = 0;
      hs = 1'b0;
      while (!hs && c < 400) begin
        iWm_Tready = toggle ? tog : 1'b1;
        tog = ~tog;
        @(negedge clk);
        hs = oBm_Tready;
        @(posedge clk);
        #1;
        c++;
      end
      if (!hs) begin
        reportFail("bmHandshakeTimeout", i, 0);
        iBm_Tvalid = 1'b0;
        iBm_Tlast  = 1'b0;
        iWm_Tready = 1'b1;
        return;
      end
    end
    iBm_Tvalid = 1'b0;
    iBm_Tlast  = 1'b0;
    iBm_Tdata  = '0;
    iWm_Tready = 1'b1;
  endtask

  task automatic waitDone(input int target, input bit legal);
    int c = 0;
    while (doneCount < target && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    checkOutput("doneCount", doneCount, target);
    if (legal) checkOutput("readyDuringDone", oCMD_Ready, 0);
    @(negedge clk);
    checkOutput("readyAfterDone", oCMD_Ready, 1);
    checkOutput("busyAfterDone", oBUSY, 0);
    checkOutput("doneIsPulse", oDONE, 0);
    checkOutput("bsQueueEmpty", expBs.size(), 0);
    checkOutput("wmQueueEmpty", expWm.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, oCMD_Ready, 1);
    checkOutput({tag, "_busy"}, oBUSY, 0);
    checkOutput({tag, "_err"}, oERR, 0);
    checkOutput({tag, "_done"}, oDONE, 0);
    checkOutput({tag, "_start"}, oFSM_START, 0);
    checkOutput({tag, "_rsReady"}, oRs_Tready, 0);
    checkOutput({tag, "_bsValid"}, oBs_Tvalid, 0);
    checkOutput({tag, "_wmValid"}, oWm_Tvalid, 0);
    checkOutput({tag, "_cfg"}, {oFSM_MODE, oCTL_Q, oCTL_NTT_Depth}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got 0 expected 1");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    iSYS_RST   = 1'b1;
    iCMD_Valid = 1'b0;
    iCMD_Mode  = '0;
    iCMD_Q     = '0;
    iCMD_Depth = '0;
    iRs_Tvalid = 1'b0;
    iRs_Tdata  = '0;
    iRs_Tlast  = 1'b0;
    iBs_Tready = 1'b1;
    iBm_Tvalid = 1'b0;
    iBm_Tdata  = '0;
    iBm_Tlast  = 1'b0;
    iWm_Tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("por");
    @(posedge clk);
    #1;
    iSYS_RST = 1'b0;

    $display("[TB] PWM nominal");
    applyStimulus(3'd0, 2'd0, 5'd0);
    hostSend(24, 24, 24, 16'h0101);
    bodySend(8, 8, 1'b0, 16'h00A1);
    expDone.push_back(3'b000);
    waitDone(1, 1'b1);

    $display("[TB] NTT with host output backpressure");
    applyStimulus(3'd1, 2'd1, 5'd4);
    hostSend(8, 8, 8, 16'h0202);
    bodySend(8, 8, 1'b1, 16'h00B2);
    expDone.push_back(3'b000);
    waitDone(2, 1'b1);
    checkOutput("cfgHoldMode", oFSM_MODE, 3'd1);
    checkOutput("cfgHoldDepth", oCTL_NTT_Depth, 5'd4);

    $display("[TB] illegal mode");
    applyStimulus(3'd5, 2'd2, 5'd2);
    waitDone(3, 1'b0);
    checkOutput("illegalErr", oERR, 3'b001);
    checkOutput("illegalCfgKept", {oFSM_MODE, oCTL_Q, oCTL_NTT_Depth}, {3'd1, 2'd1, 5'd4});

    $display("[TB] PWM with early host last");
    applyStimulus(3'd0, 2'd2, 5'd3);
    checkOutput("errClearedOnAccept", oERR, 3'b000);
    hostSend(10, 10, 24, 16'h0404);
    @(negedge clk);
    checkOutput("earlyLastErr", oERR, 3'b010);
    checkOutput("earlyLastBusy", oBUSY, 1);
    checkOutput("earlyLastLoadClosed", oRs_Tready, 0);
    @(posedge clk);
    #1;
    bodySend(8, 8, 1'b0, 16'h00C4);
    expDone.push_back(3'b010);
    waitDone(4, 1'b1);

    $display("[TB] INTT with silent body");
    applyStimulus(3'd2, 2'd0, 5'd5);
    hostSend(8, 8, 8, 16'h0505);
    c = 0;
    while (!oERR[2] && c < 5000) begin
      @(negedge clk);
      c++;
    end
    checkOutput("tmoErr", oERR, 3'b100);
    checkOutput("tmoCycles", c, TMO + 1);
    repeat (10) @(negedge clk);
    checkOutput("errStateBusy", oBUSY, 1);
    checkOutput("errStateCmdReady", oCMD_Ready, 0);
    checkOutput("errStateRsReady", oRs_Tready, 0);
    checkOutput("errStateBmReady", oBm_Tready, 0);
    checkOutput("errStateErrHeld", oERR, 3'b100);
    checkOutput("errStateNoDone", doneCount, 4);
    @(posedge clk);
    #1;
    iSYS_RST = 1'b1;
    @(posedge clk);
    #1;
    iSYS_RST = 1'b0;
    @(negedge clk);
    checkResetState("postTmo");
    @(posedge clk);
    #1;

    $display("[TB] reset during LOAD");
    applyStimulus(3'd0, 2'd3, 5'd9);
    hostSend(5, 0, 24, 16'h0606);
    iSYS_RST = 1'b1;
    @(posedge clk);
    #1;
    iSYS_RST = 1'b0;
    expBs.delete();
    @(negedge clk);
    checkResetState("midLoad");
    @(posedge clk);
    #1;
    iSYS_RST   = 1'b1;
    iCMD_Valid = 1'b1;
    iCMD_Mode  = 3'd1;
    @(posedge clk);
    #1;
    iSYS_RST   = 1'b0;
    iCMD_Valid = 1'b0;
    @(negedge clk);
    checkOutput("resetBeatsCmdBusy", oBUSY, 0);
    checkOutput("resetBeatsCmdStart", oFSM_START, 0);
    @(posedge clk);
    #1;
    applyStimulus(3'd1, 2'd2, 5'd6);
    hostSend(8, 8, 8, 16'h0707);
    bodySend(8, 8, 1'b0, 16'h00D7);
    expDone.push_back(3'b000);
    waitDone(5, 1'b1);
    checkOutput("cfgQueueEmpty", expCfg.size(), 0);
    checkOutput("doneQueueEmpty", expDone.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, errCount);
    $finish;
  end

endmodule
